// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for the 8-entry register file, plus an
// 8-cycle clear sequencer that zeroes every register via the same write port.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              req,
  input  logic [11:0]             req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_data,
  input  logic                    clr,
  output logic [3:0]              gnt,
  output logic                    wr_en,
  output logic [2:0]              wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, state_n;
  logic [1:0]              ptr, ptr_n;
  logic [2:0]              cnt, cnt_n;
  logic [3:0]              gnt_n;
  logic                    wr_en_n;
  logic [2:0]              wr_addr_n;
  logic [DATA_WIDTH-1:0]   wr_data_n;
  logic                    busy_n;

  logic [3:0]              eligible;
  logic [7:0]              doubled;
  logic [3:0]              rotated;
  logic                    hit;
  logic [1:0]              ofs;
  logic [1:0]              winner;

  // Rotate the eligible vector so bit 0 is the requester at ptr; the lowest set bit wins.
  assign eligible = req & ~gnt;
  assign doubled  = {eligible, eligible};
  assign rotated  = doubled[ptr +: 4];
  assign hit      = |rotated;

  always_comb begin
    ofs = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (rotated[i-1]) ofs = 2'(i - 1);
    end
    winner = ptr + ofs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (clr) state_n = CLEAR;
      CLEAR:   if (cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The clear-exit edge (CLEAR with cnt wrapped to 0) falls through to normal arbitration.
  always_comb begin
    gnt_n     = '0;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    busy_n    = 1'b0;
    ptr_n     = ptr;
    cnt_n     = cnt;
    if (state == IDLE && clr) begin
      busy_n    = 1'b1;
      wr_en_n   = 1'b1;
      wr_addr_n = '0;
      wr_data_n = '0;
      cnt_n     = 3'd1;
    end else if (state == CLEAR && cnt != '0) begin
      busy_n    = 1'b1;
      wr_en_n   = 1'b1;
      wr_addr_n = cnt;
      wr_data_n = '0;
      cnt_n     = cnt + 3'd1;
    end else if (hit) begin
      gnt_n     = 4'b0001 << winner;
      wr_en_n   = 1'b1;
      wr_addr_n = req_addr[3*winner +: 3];
      wr_data_n = req_data[DATA_WIDTH*winner +: DATA_WIDTH];
      ptr_n     = winner + 2'd1;
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin write-port arbiter and clear sequencer for the 8-entry register file. It accepts write requests from four requesters and grants at most one per cycle. It drives the register file's 3-to-8 write-select decoder: WR_ADDR goes to the select input, WR_EN to the enable, and WR_DATA to the register data inputs. A CLR command zeroes all eight registers in eight consecutive cycles.

## Interface
- DATA_WIDTH, 8, register width in bits
- CLK  in  1  rising-edge clock; the only clock
- RESET  in  1  synchronous, active-high reset
- REQ  in  4  write request, one bit per requester i
- REQ_ADDR  in  12  requester i's target address, bits [3i+2:3i]
- REQ_DATA  in  4*DATA_WIDTH  requester i's write data, bits [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i]
- CLR  in  1  clear command, sampled while idle
- GNT  out  4  one-hot grant, high for one cycle
- WR_EN  out  1  decoder enable
- WR_ADDR  out  3  decoder select
- WR_DATA  out  DATA_WIDTH  register write data
- BUSY  out  1  clear sequence in progress

## Operation
- States:
  - IDLE: arbitrates requests.
  - CLEAR: walks the clear counter CNT[2:0].
- All outputs are registered. Reset values: GNT=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0, state=IDLE, priority pointer PTR=0, CNT=0.
- Eligible requester: REQ[i]=1 and GNT[i]=0 at the sampling edge.
  - A requester granted in the current cycle is never granted at the next edge, so its still-high REQ is not double-counted.
  - Each requester must hold REQ, address and data stable until the first edge at which GNT[i]=1, then drop REQ at that edge. REQ still high after that edge is a new request.
- Arbitration, in IDLE with CLR=0 at an edge:
  - Search starts at PTR and runs PTR, PTR+1, … mod 4.
  - The first eligible requester k is granted:
    - GNT=1<<k, WR_EN=1, WR_ADDR=REQ_ADDR[k], WR_DATA=REQ_DATA[k].
    - PTR ← (k+1) mod 4.
  - If no requester is eligible: GNT=0, WR_EN=0, and PTR is unchanged. WR_ADDR and WR_DATA hold their last values.
- CLR=1 at an edge in IDLE:
  - CLR wins over any simultaneous requests. No grant is issued, and PTR is unchanged.
  - Next state is CLEAR, with BUSY=1, WR_EN=1, WR_ADDR=0, WR_DATA=0, GNT=0, CNT=1.
- Each CLEAR edge:
  - While CNT≠0: WR_ADDR=CNT, WR_DATA=0, WR_EN=1, CNT ← CNT+1. The counter wraps 7→0.
  - When CNT wraps to 0, the cycle that presented address 7 is over. That edge returns to IDLE and performs a normal arbitration in the same edge, so BUSY=0 and a grant may appear together.
- CLR asserted during CLEAR is ignored. Requests during CLEAR stay pending, and no GNT is issued.
- RESET in the middle of CLEAR aborts the sequence. All outputs go to their reset values on the next cycle, and the remaining addresses are not written.
- Two requesters targeting the same address are serialized in grant order; the later write wins.

## Timing
- Request-to-write latency is 1 cycle. Inputs are sampled at edge E, and GNT/WR_* are valid for the whole cycle following E.
- Throughput:
  - One write per cycle overall.
  - A single requester can receive at most one grant every 2 cycles.
  - Different requesters can be granted back-to-back.
- Clear takes 8 cycles of WR_EN=1 (addresses 0..7), with BUSY high for exactly those 8 cycles.
- GNT is never asserted while BUSY=1. WR_EN=1 whenever GNT≠0 or BUSY=1, and WR_EN=0 otherwise.

## Test plan
- Reset, then idle for 3 cycles: all outputs 0. REQ=0001, addr 5, data 8'hA5 → next cycle GNT=0001, WR_EN=1, WR_ADDR=5, WR_DATA=8'hA5. The following cycle has no grant while REQ is still high at the grant edge.
- All four requesters held high from PTR=0: grants appear 0,1,2,3 on consecutive cycles, each with its own address and data. Then GNT=0 once every REQ has been dropped.
- Requester 2 alone keeps REQ high for 6 cycles: GNT[2] alternates 1,0,1,0,…. PTR ends at 3, and requester 3's next request is granted ahead of requester 0.
- CLR=1 together with REQ=0110: BUSY=1 for 8 cycles with WR_ADDR 0..7, WR_DATA=0 and GNT=0. On the cycle after address 7, BUSY=0 and GNT=0010.
- RESET asserted while CLEAR is presenting WR_ADDR=3 → next cycle all outputs 0 and state IDLE. A subsequent REQ=1000 is granted with PTR starting from 0.
- Requesters 0 and 1 both target address 4 with data 11 and 22: writes occur in grant order 0 then 1, and the register file holds 22.
